// File: rtl/int_pkg.sv
// Shared types and register map for the Z80 mode-2 interrupt vector controller.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_PEND  = 2'd1;
  localparam logic [1:0] A_EOI   = 2'd2;
  localparam logic [1:0] A_VBASE = 2'd3;

endpackage

// File: rtl/int_edge_capture.sv
// Rising-edge detector and pending latches for the interrupt sources.
// A set and a clear of the same bit in one cycle resolve in favour of the set,
// so an edge arriving during a software clear is never lost.
module int_edge_capture #(
  parameter int NSRC = 8
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] pend_clr,
  output logic [NSRC-1:0] pending
);

  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] rise;

  assign rise = irq_src & ~src_d;

  // Delay the sources by one cycle and accumulate edges into the pending latches
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      src_d   <= '0;
      pending <= '0;
    end else begin
      src_d   <= irq_src;
      pending <= (pending & ~pend_clr) | rise;
    end
  end

endmodule

// File: rtl/int_vector_ctrl.sv
// Z80 mode-2 interrupt controller: captures source edges, drives the external
// priority encoder, answers the acknowledge cycle with a vector byte and holds
// off further interrupts until software writes EOI.
module int_vector_ctrl
  import int_pkg::*;
#(
  parameter int          NSRC    = 8,
  parameter logic [3:0]  VEC_RST = 4'h0
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] req_n,
  input  logic [2:0]      enc_q,
  input  logic            enc_gs,
  input  logic            m1_n,
  input  logic            iorq_n,
  output logic            int_n,
  output logic [7:0]      vec_dout,
  output logic            vec_oe,
  input  logic            io_wr,
  input  logic            io_rd,
  input  logic [1:0]      io_addr,
  input  logic [7:0]      io_din,
  output logic [7:0]      io_dout
);

  state_t          state, state_nxt;
  logic [2:0]      lvl, lvl_nxt;
  logic            spur, spur_nxt;
  logic            int_n_nxt;
  logic [NSRC-1:0] mask;
  logic [3:0]      vbase;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] ack_clr;
  logic            ack;
  logic            eoi_wr;
  logic            unused_rd;

  // Reads have no side effects, so the read strobe carries no information here.
  assign unused_rd = io_rd;

  assign ack      = ~m1_n & ~iorq_n;
  assign eoi_wr   = io_wr && (io_addr == A_EOI);
  assign pend_clr = ((io_wr && (io_addr == A_PEND)) ? io_din[NSRC-1:0] : '0) | ack_clr;
  assign req_n    = ~(pending & mask);

  int_edge_capture #(.NSRC(NSRC)) u_capture (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .irq_src  (irq_src),
    .pend_clr (pend_clr),
    .pending  (pending)
  );

  // Software-visible MASK and VBASE registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mask  <= '0;
      vbase <= VEC_RST;
    end else if (io_wr) begin
      if (io_addr == A_MASK)  mask  <= io_din[NSRC-1:0];
      if (io_addr == A_VBASE) vbase <= io_din[7:4];
    end
  end

  // State register together with the latched level, spurious flag and INT line
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      lvl   <= 3'd0;
      spur  <= 1'b0;
      int_n <= 1'b1;
    end else begin
      state <= state_nxt;
      lvl   <= lvl_nxt;
      spur  <= spur_nxt;
      int_n <= int_n_nxt;
    end
  end

  // Acknowledge sequencing: vector output, in-service hold-off and ack-time clear
  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    spur_nxt  = spur;
    int_n_nxt = int_n;
    ack_clr   = '0;
    vec_oe    = 1'b0;
    vec_dout  = 8'h00;
    case (state)
      IDLE: begin
        int_n_nxt = enc_gs;
        if (ack) begin
          state_nxt = ACK;
          spur_nxt  = enc_gs;
          lvl_nxt   = enc_gs ? 3'd0 : ~enc_q;
        end
      end
      ACK: begin
        int_n_nxt = 1'b1;
        vec_oe    = 1'b1;
        vec_dout  = {vbase, lvl, 1'b0};
        if (iorq_n) begin
          if (!spur) begin
            ack_clr[lvl] = 1'b1;
            state_nxt    = SERVICE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SERVICE: begin
        int_n_nxt = 1'b1;
        if (eoi_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register read-back mux
  always_comb begin
    io_dout = 8'h00;
    case (io_addr)
      A_MASK:  io_dout = 8'(mask);
      A_PEND:  io_dout = 8'(pending);
      A_EOI:   io_dout = 8'h00;
      A_VBASE: io_dout = {vbase, 4'h0};
      default: io_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Self-checking bench for int_vector_ctrl with an 8-to-3 priority encoder
// (active-low inputs and outputs, input 7 highest) wired between req_n and enc_q/enc_gs.
module tb_int_vector_ctrl;
  import int_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_src = 8'h00;
  logic [7:0] req_n;
  logic [2:0] enc_q;
  logic       enc_gs;
  logic       m1_n = 1'b1;
  logic       iorq_n = 1'b1;
  logic       int_n;
  logic [7:0] vec_dout;
  logic       vec_oe;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [1:0] io_addr = 2'd0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout;

  int numChecks = 0;
  int numFails  = 0;
  logic [7:0] expQ[$];

  typedef struct {
    string      name;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } reg_vec_t;

  typedef struct {
    int         src;
    logic [7:0] vec;
  } lvl_vec_t;

  reg_vec_t regTab[8];
  lvl_vec_t lvlTab[8];

  int_vector_ctrl #(.NSRC(8), .VEC_RST(4'h0)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .irq_src  (irq_src),
    .req_n    (req_n),
    .enc_q    (enc_q),
    .enc_gs   (enc_gs),
    .m1_n     (m1_n),
    .iorq_n   (iorq_n),
    .int_n    (int_n),
    .vec_dout (vec_dout),
    .vec_oe   (vec_oe),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_dout  (io_dout)
  );

  // External priority encoder: highest active-low input wins, outputs active low
  always_comb begin
    enc_gs = 1'b1;
    enc_q  = 3'b111;
    for (int i = 0; i < 8; i++) begin
      if (!req_n[i]) begin
        enc_gs = 1'b0;
        enc_q  = ~3'(i);
      end
    end
  end

  always #5 clk_sys = ~clk_sys;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkPopped(input string name, input logic [7:0] act);
    if (expQ.size() == 0) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL %s: got %h expected nothing queued", name, act);
    end else begin
      checkOutput(name, act, expQ.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ioWrite(input logic [1:0] a, input logic [7:0] d);
    io_addr = a;
    io_din  = d;
    io_wr   = 1'b1;
    cyc();
    io_wr   = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [7:0] exp);
    io_addr = a;
    io_rd   = 1'b1;
    #1;
    checkOutput(name, io_dout, exp);
    io_rd   = 1'b0;
  endtask

  task automatic pulse(input int k);
    irq_src[k] = 1'b1;
    cyc();
    irq_src[k] = 1'b0;
  endtask

  task automatic doAck(input string name, input logic [7:0] expVec);
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    expQ.push_back(expVec);
    cyc();
    checkBit({name, " vec_oe"}, vec_oe, 1'b1);
    checkPopped({name, " vec_dout"}, vec_dout);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    cyc();
    checkBit({name, " vec_oe released"}, vec_oe, 1'b0);
  endtask

  task automatic applyStimulus(input reg_vec_t v);
    if (v.wr) ioWrite(v.addr, v.din);
    expQ.push_back(v.exp);
    io_addr = v.addr;
    io_rd   = 1'b1;
    #1;
    checkPopped(v.name, io_dout);
    io_rd   = 1'b0;
  endtask

  initial begin
    regTab[0] = '{"mask rw 5A",   1'b1, A_MASK,  8'h5A, 8'h5A};
    regTab[1] = '{"mask rw 00",   1'b1, A_MASK,  8'h00, 8'h00};
    regTab[2] = '{"vbase wr A7",  1'b1, A_VBASE, 8'hA7, 8'hA0};
    regTab[3] = '{"vbase rd",     1'b0, A_VBASE, 8'h00, 8'hA0};
    regTab[4] = '{"eoi reads 0",  1'b1, A_EOI,   8'hFF, 8'h00};
    regTab[5] = '{"pend idle",    1'b0, A_PEND,  8'h00, 8'h00};
    regTab[6] = '{"pend w1c FF",  1'b1, A_PEND,  8'hFF, 8'h00};
    regTab[7] = '{"vbase wr 3C",  1'b1, A_VBASE, 8'h3C, 8'h30};
    lvlTab[0] = '{0, 8'hA0};
    lvlTab[1] = '{1, 8'hA2};
    lvlTab[2] = '{2, 8'hA4};
    lvlTab[3] = '{3, 8'hA6};
    lvlTab[4] = '{4, 8'hA8};
    lvlTab[5] = '{5, 8'hAA};
    lvlTab[6] = '{6, 8'hAC};
    lvlTab[7] = '{7, 8'hAE};

    // Reset values
    cyc();
    cyc();
    checkBit("reset int_n", int_n, 1'b1);
    checkBit("reset vec_oe", vec_oe, 1'b0);
    checkOutput("reset vec_dout", vec_dout, 8'h00);
    checkOutput("reset req_n", req_n, 8'hFF);
    readCheck("reset MASK", A_MASK, 8'h00);
    readCheck("reset VBASE", A_VBASE, 8'h00);
    reset_n = 1'b1;
    cyc();

    // Register access table
    foreach (regTab[i]) applyStimulus(regTab[i]);

    ioWrite(A_VBASE, 8'hA0);
    ioWrite(A_MASK, 8'hFF);

    // Single source 2: latency, vector, ack-time clear, no nesting
    pulse(2);
    checkOutput("src2 req_n", req_n, 8'hFB);
    checkBit("src2 int_n n+1", int_n, 1'b1);
    readCheck("src2 PEND", A_PEND, 8'h04);
    cyc();
    checkBit("src2 int_n n+2", int_n, 1'b0);
    doAck("src2 ack", 8'hA4);
    readCheck("src2 PEND cleared", A_PEND, 8'h00);
    checkBit("src2 int_n service", int_n, 1'b1);
    pulse(7);
    cyc();
    cyc();
    checkBit("no nesting int_n", int_n, 1'b1);
    readCheck("service accumulates", A_PEND, 8'h80);
    ioWrite(A_EOI, 8'h00);
    cyc();
    checkBit("after eoi int_n", int_n, 1'b0);
    doAck("src7 ack", 8'hAE);
    ioWrite(A_EOI, 8'h00);

    // Simultaneous edges on 3 and 6
    irq_src = 8'h48;
    cyc();
    irq_src = 8'h00;
    cyc();
    checkBit("3+6 int_n", int_n, 1'b0);
    doAck("3+6 first", 8'hAC);
    readCheck("3+6 PEND", A_PEND, 8'h08);
    ioWrite(A_EOI, 8'h00);
    checkBit("3+6 int_n at eoi", int_n, 1'b1);
    cyc();
    checkBit("3+6 int_n reassert", int_n, 1'b0);
    doAck("3+6 second", 8'hA6);
    ioWrite(A_EOI, 8'h00);
    readCheck("3+6 PEND empty", A_PEND, 8'h00);

    // Masked source, then unmask
    ioWrite(A_MASK, 8'h00);
    pulse(5);
    cyc();
    cyc();
    checkBit("masked int_n", int_n, 1'b1);
    readCheck("masked PEND", A_PEND, 8'h20);
    checkOutput("masked req_n", req_n, 8'hFF);
    ioWrite(A_MASK, 8'h20);
    checkOutput("unmask req_n", req_n, 8'hDF);
    checkBit("unmask int_n +1", int_n, 1'b1);
    cyc();
    checkBit("unmask int_n +2", int_n, 1'b0);
    doAck("unmask ack", 8'hAA);
    ioWrite(A_EOI, 8'h00);

    // Clear and edge on the same bit in one cycle; held level is ignored
    ioWrite(A_MASK, 8'h00);
    pulse(5);
    cyc();
    irq_src[5] = 1'b1;
    ioWrite(A_PEND, 8'h20);
    readCheck("set beats clear", A_PEND, 8'h20);
    cyc();
    ioWrite(A_PEND, 8'h20);
    readCheck("w1c clears", A_PEND, 8'h00);
    cyc();
    cyc();
    readCheck("level ignored", A_PEND, 8'h00);
    irq_src[5] = 1'b0;
    cyc();

    // Spurious acknowledge with only a masked pending bit
    pulse(5);
    cyc();
    checkOutput("spur req_n", req_n, 8'hFF);
    doAck("spurious", 8'hA0);
    readCheck("spur PEND kept", A_PEND, 8'h20);
    ioWrite(A_MASK, 8'h20);
    cyc();
    checkBit("spur back to idle", int_n, 1'b0);
    doAck("after spur", 8'hAA);
    ioWrite(A_EOI, 8'h00);

    // Higher-priority edge during ACK does not change the vector
    ioWrite(A_MASK, 8'hFF);
    pulse(1);
    cyc();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    expQ.push_back(8'hA2);
    cyc();
    irq_src[7] = 1'b1;
    cyc();
    irq_src[7] = 1'b0;
    checkPopped("frozen lvl vec_dout", vec_dout);
    checkBit("ack int_n released", int_n, 1'b1);
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    cyc();
    readCheck("frozen PEND", A_PEND, 8'h80);
    ioWrite(A_EOI, 8'h00);
    cyc();
    doAck("frozen next", 8'hAE);
    ioWrite(A_EOI, 8'h00);

    // Every level through the encoder
    foreach (lvlTab[i]) begin
      pulse(lvlTab[i].src);
      cyc();
      checkBit($sformatf("lvl%0d int_n", lvlTab[i].src), int_n, 1'b0);
      doAck($sformatf("lvl%0d", lvlTab[i].src), lvlTab[i].vec);
      readCheck($sformatf("lvl%0d PEND", lvlTab[i].src), A_PEND, 8'h00);
      ioWrite(A_EOI, 8'h00);
    end

    // Reset in the middle of an acknowledge
    pulse(4);
    cyc();
    m1_n   = 1'b0;
    iorq_n = 1'b0;
    cyc();
    checkBit("pre-reset vec_oe", vec_oe, 1'b1);
    pulse(6);
    reset_n = 1'b0;
    cyc();
    checkBit("mid-ack reset vec_oe", vec_oe, 1'b0);
    checkBit("mid-ack reset int_n", int_n, 1'b1);
    checkOutput("mid-ack reset vec_dout", vec_dout, 8'h00);
    checkOutput("mid-ack reset req_n", req_n, 8'hFF);
    readCheck("mid-ack reset PEND", A_PEND, 8'h00);
    readCheck("mid-ack reset MASK", A_MASK, 8'h00);
    readCheck("mid-ack reset VBASE", A_VBASE, 8'h00);
    m1_n    = 1'b1;
    iorq_n  = 1'b1;
    reset_n = 1'b1;
    cyc();
    cyc();
    checkBit("post-reset int_n", int_n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
